alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 108 ++++++++++
 tb/tb_alu_result_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Result buffer between an ALU and writeback: a DEPTH-entry FIFO of {result, flags, rd}.
// Results with rd = 0 are not stored. They are counted in drop_cnt instead.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [3:0]               in_flags,
  input  logic [4:0]               in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_flags,
  output logic [4:0]               out_rd,
  input  logic                     clr_sticky,
  output logic                     sticky_ovf,
  output logic                     sticky_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [31:0]     mem_result_q [DEPTH];
  logic [3:0]      mem_flags_q  [DEPTH];
  logic [4:0]      mem_rd_q     [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            sticky_ovf_q, sticky_ovf_d;
  logic            sticky_carry_q, sticky_carry_d;

  logic            push, pop, store;

  assign in_ready  = (count_q < FullCnt);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign store     = push & (in_rd != 5'd0);

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    drop_cnt_d     = drop_cnt_q;
    sticky_ovf_d   = sticky_ovf_q & ~clr_sticky;
    sticky_carry_d = sticky_carry_q & ~clr_sticky;

    // Power-of-two depth, so the natural pointer overflow is the modulo wrap.
    if (store) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    case ({store, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push && !store && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    // A set on this cycle's push wins over clr_sticky.
    if (push && in_flags[1]) sticky_ovf_d   = 1'b1;
    if (push && in_flags[2]) sticky_carry_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      drop_cnt_q     <= '0;
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      drop_cnt_q     <= drop_cnt_d;
      sticky_ovf_q   <= sticky_ovf_d;
      sticky_carry_q <= sticky_carry_d;
    end
  end

  // Storage is deliberately left out of reset; head outputs are don't-care while empty.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_result_q[wr_ptr_q] <= in_result;
      mem_flags_q[wr_ptr_q]  <= in_flags;
      mem_rd_q[wr_ptr_q]     <= in_rd;
    end
  end

  assign out_result   = mem_result_q[rd_ptr_q];
  assign out_flags    = mem_flags_q[rd_ptr_q];
  assign out_rd       = mem_rd_q[rd_ptr_q];
  assign count        = count_q;
  assign drop_cnt     = drop_cnt_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign sticky_carry = sticky_carry_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_result;
  logic [3:0]      in_flags;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic [3:0]      out_flags;
  logic [4:0]      out_rd;
  logic            clr_sticky;
  logic            sticky_ovf;
  logic            sticky_carry;
  logic [CntW-1:0] count;
  logic [7:0]      drop_cnt;

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_rd       (out_rd),
    .clr_sticky   (clr_sticky),
    .sticky_ovf   (sticky_ovf),
    .sticky_carry (sticky_carry),
    .count        (count),
    .drop_cnt     (drop_cnt)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [4:0]  rd;
  } entry_t;

  entry_t mq[$];
  int     m_drop;
  bit     m_ovf, m_carry;
  bit     model_ok = 1'b0;
  bit     m_push, m_pop;
  int     n_cmp  = 0;
  int     n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO as a queue, updated from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_drop   = 0;
      m_ovf    = 1'b0;
      m_carry  = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_push = in_valid && (mq.size() < int'(DEPTH));
      m_pop  = (mq.size() != 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (in_rd != 5'd0) mq.push_back({in_result, in_flags, in_rd});
        else if (m_drop < 255) m_drop++;
      end
      if (clr_sticky) begin
        m_ovf   = 1'b0;
        m_carry = 1'b0;
      end
      if (m_push && in_flags[1]) m_ovf   = 1'b1;
      if (m_push && in_flags[2]) m_carry = 1'b1;
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("in_ready", 32'(in_ready), 32'(mq.size() < int'(DEPTH)));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("count", 32'(count), 32'(mq.size()));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("sticky_ovf", 32'(sticky_ovf), 32'(m_ovf));
      check("sticky_carry", 32'(sticky_carry), 32'(m_carry));
      if (mq.size() != 0) begin
        check("out_result", out_result, mq[0].res);
        check("out_flags", 32'(out_flags), 32'(mq[0].flg));
        check("out_rd", 32'(out_rd), 32'(mq[0].rd));
      end
    end
  end

  task automatic cycle(input bit v, input logic [31:0] r, input logic [3:0] f,
                       input logic [4:0] d, input bit ordy, input bit clr, input bit rst);
    in_valid   = v;
    in_result  = r;
    in_flags   = f;
    in_rd      = d;
    out_ready  = ordy;
    clr_sticky = clr;
    reset      = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    in_valid   = 1'b0;
    in_result  = '0;
    in_flags   = '0;
    in_rd      = '0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    reset      = 1'b1;
    do_reset();
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Single push, one-cycle latency.
    cycle(1'b1, 32'h0000_0005, 4'b0000, 5'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_result", out_result, 32'h5);
    check("lat_out_rd", 32'(out_rd), 32'd3);
    check("lat_count", 32'(count), 32'd1);

    // Fill, overflow attempt ignored, drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i * 16), 4'h0, 5'(i), 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'hDEAD, 4'h0, 5'd9, 1'b0, 1'b0, 1'b0);
    check("full_ignore_count", 32'(count), 32'd4);
    check("full_ignore_head", 32'(out_rd), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_rd", 32'(out_rd), 32'(i));
      cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    end
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Full with simultaneous pop and in_valid: pop only, then push next cycle.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 4'h0, 5'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h77, 4'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_head", 32'(out_rd), 32'd2);
    cycle(1'b1, 32'h77, 4'h0, 5'd7, 1'b0, 1'b0, 1'b0);
    check("fullpush_count", 32'(count), 32'd4);

    // rd = 0 drops and saturation.
    do_reset();
    cycle(1'b1, 32'h1, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0);
    check("drop_count", 32'(count), 32'd0);
    check("drop_cnt1", 32'(drop_cnt), 32'd1);
    check("drop_ovf", 32'(sticky_ovf), 32'd1);
    for (int i = 0; i < 255; i++) cycle(1'b1, 32'h1, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0);
    check("drop_sat", 32'(drop_cnt), 32'd255);

    // Sticky set beats clear; clear alone then clears.
    do_reset();
    cycle(1'b1, 32'h2, 4'b0100, 5'd5, 1'b0, 1'b1, 1'b0);
    check("sticky_set_prio", 32'(sticky_carry), 32'd1);
    cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("sticky_clr", 32'(sticky_carry), 32'd0);

    // Reset beats push/pop; then pointer wrap with push/pop pairs.
    do_reset();
    cycle(1'b1, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA1, 4'h0, 5'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 4'h0, 5'd2, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    cycle(1'b1, 32'hA3, 4'h0, 5'd3, 1'b1, 1'b0, 1'b1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    cycle(1'b1, 32'hB0, 4'h0, 5'd10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i), 4'h0, 5'(11 + i), 1'b1, 1'b0, 1'b0);
    check("wrap_count", 32'(count), 32'd1);
    check("wrap_head_rd", 32'(out_rd), 32'd20);
    check("wrap_head_res", out_result, 32'd9);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
            (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 99) == 0));
    end
    cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
